// File: rtl/spi_mem_controller_pkg.sv
// Shared types and constants for the SPI memory transaction sequencer.
package spi_mem_controller_pkg;

  // State codes double as the debug LED value, so the encoding is fixed.
  typedef enum logic [3:0] {
    S_IDLE      = 4'h0,
    S_CMD       = 4'h1,
    S_LATCH     = 4'h2,
    S_RD_LOAD   = 4'h3,
    S_RD_SHIFT  = 4'h4,
    S_RD_NEXT   = 4'h5,
    S_WR_SHIFT  = 4'h6,
    S_WR_COMMIT = 4'h7,
    S_DONE      = 4'h8
  } state_t;

  localparam int BYTE_BITS_DEF = 8;

  // Command byte is {addr[6:0], rw}; rw sits in the LSB.
  localparam int CMD_RW_BIT = 0;

  // States in which conditioned SCLK rising edges are counted.
  function automatic logic is_count_state(input state_t s);
    return (s == S_CMD) || (s == S_RD_SHIFT) || (s == S_WR_SHIFT);
  endfunction

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_mem_controller_if.sv
// Bus between the input conditioners / datapath and the transaction sequencer.
interface spi_mem_controller_if #(
  parameter int ADDR_WIDTH = 7
) ();

  logic                  cs_n;
  logic                  sclk_posedge;
  logic                  sclk_negedge;
  logic [7:0]            sr_data;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  sr_we;
  logic                  dm_we;
  logic                  miso_en;
  logic                  busy;
  logic [3:0]            leds;

  // Environment side: conditioners and shift register drive, strobes return.
  modport master (
    output cs_n, sclk_posedge, sclk_negedge, sr_data,
    input  addr, sr_we, dm_we, miso_en, busy, leds
  );

  // Sequencer side.
  modport slave (
    input  cs_n, sclk_posedge, sclk_negedge, sr_data,
    output addr, sr_we, dm_we, miso_en, busy, leds
  );

endinterface

// File: rtl/spi_mem_controller_bit_counter.sv
// SCLK rising-edge counter for one byte frame, with a terminal-count pulse.
module spi_mem_controller_bit_counter
  import spi_mem_controller_pkg::*;
#(
  parameter int BYTE_BITS = BYTE_BITS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic inc,
  output logic tc
);

  localparam int CNT_W = cnt_width(BYTE_BITS);

  logic [CNT_W-1:0] cnt;
  logic             step;

  // An edge only counts while enabled, so an abort in the same clk wins.
  assign step = en && inc;
  assign tc   = step && (cnt == CNT_W'(BYTE_BITS - 1));

  // Hold at zero while disabled, restart after each full byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!en || tc) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_mem_controller.sv
// SPI memory transaction sequencer: command decode, address register with
// burst auto-increment, and registered strobes for shift register, memory
// write and MISO enable.
module spi_mem_controller
  import spi_mem_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int BYTE_BITS  = BYTE_BITS_DEF,
  parameter int BURST_EN   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_mem_controller_if.slave  bus
);

  localparam bit BURST = (BURST_EN != 0);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  rw_q;
  logic                  rw_nxt;
  logic                  cnt_en;
  logic                  byte_done;
  logic                  unused_sclk_negedge;

  // Address step wraps modulo 2^ADDR_WIDTH with no overflow indication.
  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return a + ADDR_WIDTH'(1);
  endfunction

  // Falling edges are decoded upstream but MISO timing lives downstream.
  assign unused_sclk_negedge = bus.sclk_negedge;

  assign cnt_en = is_count_state(state) && !bus.cs_n;

  spi_mem_controller_bit_counter #(
    .BYTE_BITS (BYTE_BITS)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .inc   (bus.sclk_posedge),
    .tc    (byte_done)
  );

  // State, address and direction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      addr_q <= '0;
      rw_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      rw_q   <= rw_nxt;
    end
  end

  // Next-state and register-update decode; CS release aborts everywhere
  // except the write commit, which must finish its memory write.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    rw_nxt    = rw_q;
    if (bus.cs_n && (state != S_WR_COMMIT)) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          state_nxt = S_CMD;
        end
        S_CMD: begin
          if (byte_done) state_nxt = S_LATCH;
        end
        S_LATCH: begin
          addr_nxt  = ADDR_WIDTH'(bus.sr_data[7:CMD_RW_BIT+1]);
          rw_nxt    = bus.sr_data[CMD_RW_BIT];
          state_nxt = bus.sr_data[CMD_RW_BIT] ? S_RD_LOAD : S_WR_SHIFT;
        end
        S_RD_LOAD: begin
          state_nxt = S_RD_SHIFT;
        end
        S_RD_SHIFT: begin
          if (byte_done) state_nxt = S_RD_NEXT;
        end
        S_RD_NEXT: begin
          if (BURST) begin
            addr_nxt  = addr_inc(addr_q);
            state_nxt = S_RD_LOAD;
          end else begin
            state_nxt = S_DONE;
          end
        end
        S_WR_SHIFT: begin
          if (byte_done) state_nxt = S_WR_COMMIT;
        end
        S_WR_COMMIT: begin
          if (bus.cs_n) begin
            state_nxt = S_IDLE;
          end else if (BURST) begin
            addr_nxt  = addr_inc(addr_q);
            state_nxt = S_WR_SHIFT;
          end else begin
            state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          state_nxt = S_DONE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Strobes decode purely from registered state; direction qualifies the
  // load/write pulses so a corrupted state code cannot fire the wrong one.
  assign bus.addr    = addr_q;
  assign bus.sr_we   = (state == S_RD_LOAD) && rw_q;
  assign bus.dm_we   = (state == S_WR_COMMIT) && !rw_q;
  assign bus.miso_en = (state == S_RD_SHIFT) || (state == S_RD_NEXT);
  assign bus.busy    = (state != S_IDLE);
  assign bus.leds    = state;

endmodule
